emg_multi_ch: RTL and testbench

//  Multi-channel EMG synthesiser; next generation of the single-pool emg block.
//  Per sim_clk sample, takes one spike count per motoneuron pool (NCH channels).

---
 rtl/emg_pkg.sv | 43 ++++
 rtl/emg_mac_unit.sv | 45 ++++
 rtl/emg_multi_ch.sv | 182 ++++++++++++++++++
 tb/tb_emg_multi_ch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/emg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | emg_pkg : shared widths, FSM encoding and saturation for emg_multi_ch |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package emg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_w(input int cnt_w, input int coef_w, input int taps);
        return cnt_w + coef_w + 1 + $clog2(taps);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (out_w >= 64) begin
            return v;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/emg_mac_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | emg_mac_unit : unsigned-count x signed-coef MAC with clear/enable     |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module emg_mac_unit
    import emg_pkg::*;
#(
    parameter int CNT_W  = 9,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 32,
    parameter int ACC_W  = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic        [CNT_W-1:0]  cnt,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [ACC_W-1:0]  acc_next,
    output logic signed [OUT_W-1:0]  result_sat
);

    localparam int PROD_W = CNT_W + COEF_W + 1;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;

    assign prod = $signed({1'b0, cnt}) * coef;

    // acc_next already includes the current product, so a channel result is
    // available in the same cycle its last tap is presented.
    assign acc_next   = (clr ? '0 : acc) + ACC_W'(prod);
    assign result_sat = OUT_W'(saturate(64'(acc_next), OUT_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/emg_multi_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | emg_multi_ch : multi-channel EMG synthesiser, shared time-mux MAC     |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module emg_multi_ch
    import emg_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int TAPS   = 16,
    parameter int CNT_W  = 9,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_stb,
    input  logic [NCH*CNT_W-1:0]       spk_cnt,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic [NCH*OUT_W-1:0]       emg_out,
    output logic signed [OUT_W-1:0]    emg_sum,
    output logic                       emg_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic                       coef_err
);

    localparam int TAP_W = idx_w(TAPS);
    localparam int CH_W  = idx_w(NCH);
    localparam int ACC_W = acc_w(CNT_W, COEF_W, TAPS);
    localparam int SUM_W = ACC_W + CH_W;

    state_t                   state;
    state_t                   state_next;
    logic [NCH*CNT_W-1:0]     cnt_cap;
    logic [CNT_W-1:0]         hist [NCH][TAPS];
    logic signed [COEF_W-1:0] coef_wr  [TAPS];
    logic signed [COEF_W-1:0] coef_act [TAPS];
    logic [CH_W-1:0]          ch_idx;
    logic [TAP_W-1:0]         tap_idx;
    logic signed [ACC_W-1:0]  stage_raw [NCH];
    logic signed [OUT_W-1:0]  stage_sat [NCH];
    logic                     last_tap;
    logic                     last_ch;
    logic                     mac_en;
    logic                     mac_clr;
    logic [CNT_W-1:0]         mac_cnt;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [ACC_W-1:0]  mac_acc;
    logic signed [OUT_W-1:0]  mac_sat;
    logic signed [SUM_W-1:0]  sum_full;
    logic signed [OUT_W-1:0]  sum_sat;

    assign last_tap = (tap_idx == TAP_W'(TAPS - 1));
    assign last_ch  = (ch_idx == CH_W'(NCH - 1));
    assign mac_cnt  = hist[ch_idx][tap_idx];
    assign mac_coef = coef_act[tap_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        mac_en     = (state == ST_ACCUM);
        mac_clr    = (tap_idx == '0);
        case (state)
            ST_IDLE:  if (sample_stb) state_next = ST_SHIFT;
            ST_SHIFT: state_next = ST_ACCUM;
            ST_ACCUM: if (last_tap && last_ch) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Writes land in a shadow kernel; the active kernel is snapshotted when a
    // sample is accepted, so a same-cycle write only affects later samples.
    always_ff @(posedge clk) begin
        if (coef_we && state == ST_IDLE) begin
            coef_wr[coef_addr] <= coef_data;
        end
        if (sample_stb && state == ST_IDLE) begin
            coef_act <= coef_wr;
        end
    end

    always_comb begin
        sum_full = '0;
        for (int c = 0; c < NCH; c++) begin
            sum_full = sum_full + SUM_W'(stage_raw[c]);
        end
        sum_sat = OUT_W'(saturate(64'(sum_full), OUT_W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_cap   <= '0;
            ch_idx    <= '0;
            tap_idx   <= '0;
            emg_out   <= '0;
            emg_sum   <= '0;
            emg_valid <= 1'b0;
            overrun   <= 1'b0;
            coef_err  <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                stage_raw[c] <= '0;
                stage_sat[c] <= '0;
                for (int k = 0; k < TAPS; k++) begin
                    hist[c][k] <= '0;
                end
            end
        end else begin
            emg_valid <= 1'b0;
            if (sample_stb && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            if (coef_we && state != ST_IDLE) begin
                coef_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    ch_idx  <= '0;
                    tap_idx <= '0;
                    if (sample_stb) begin
                        cnt_cap <= spk_cnt;
                    end
                end
                ST_SHIFT: begin
                    for (int c = 0; c < NCH; c++) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            hist[c][k] <= hist[c][k-1];
                        end
                        hist[c][0] <= cnt_cap[c*CNT_W +: CNT_W];
                    end
                end
                ST_ACCUM: begin
                    if (last_tap) begin
                        stage_raw[ch_idx] <= mac_acc;
                        stage_sat[ch_idx] <= mac_sat;
                        tap_idx           <= '0;
                        ch_idx            <= ch_idx + 1'b1;
                    end else begin
                        tap_idx <= tap_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    for (int c = 0; c < NCH; c++) begin
                        emg_out[c*OUT_W +: OUT_W] <= stage_sat[c];
                    end
                    emg_sum   <= sum_sat;
                    emg_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    emg_mac_unit #(
        .CNT_W  (CNT_W),
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk        (clk),
        .reset      (reset),
        .clr        (mac_clr),
        .en         (mac_en),
        .cnt        (mac_cnt),
        .coef       (mac_coef),
        .acc_next   (mac_acc),
        .result_sat (mac_sat)
    );

endmodule
`default_nettype wire

// File: tb/tb_emg_multi_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_emg_multi_ch : directed self-checking bench for emg_multi_ch        |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_emg_multi_ch;

    localparam int NCH = 4;
    localparam int TAPS = 16;
    localparam int CNT_W = 9;
    localparam int COEF_W = 16;
    localparam int LAT = NCH * TAPS + 2;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     sample_stb = 1'b0;
    logic [NCH*CNT_W-1:0]     spk_cnt = '0;
    logic                     coef_we = 1'b0;
    logic [3:0]               coef_addr = '0;
    logic signed [COEF_W-1:0] coef_data = '0;

    logic [NCH*32-1:0]  emg_out;
    logic signed [31:0] emg_sum;
    logic               emg_valid, busy, overrun, coef_err;
    logic [NCH*20-1:0]  emg_out_s;
    logic signed [19:0] emg_sum_s;
    logic               emg_valid_s, busy_s, overrun_s, coef_err_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    emg_multi_ch #(.NCH(NCH), .TAPS(TAPS), .CNT_W(CNT_W), .COEF_W(COEF_W), .OUT_W(32)) dut (
        .clk(clk), .reset(reset), .sample_stb(sample_stb), .spk_cnt(spk_cnt),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .emg_out(emg_out), .emg_sum(emg_sum), .emg_valid(emg_valid), .busy(busy),
        .overrun(overrun), .coef_err(coef_err)
    );

    emg_multi_ch #(.NCH(NCH), .TAPS(TAPS), .CNT_W(CNT_W), .COEF_W(COEF_W), .OUT_W(20)) dut_s (
        .clk(clk), .reset(reset), .sample_stb(sample_stb), .spk_cnt(spk_cnt),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .emg_out(emg_out_s), .emg_sum(emg_sum_s), .emg_valid(emg_valid_s), .busy(busy_s),
        .overrun(overrun_s), .coef_err(coef_err_s)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] ch32(input int i);
        logic [31:0] v;
        v = emg_out[i*32 +: 32];
        return 64'($signed(v));
    endfunction

    function automatic logic signed [63:0] ch20(input int i);
        logic [19:0] v;
        v = emg_out_s[i*20 +: 20];
        return 64'($signed(v));
    endfunction

    function automatic logic [NCH*CNT_W-1:0] mk(input int c0, input int c1, input int c2, input int c3);
        return {9'(c3), 9'(c2), 9'(c1), 9'(c0)};
    endfunction

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_coef(input int a, input int d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = 16'(d);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic load_unit(input int a, input int d);
        for (int i = 0; i < TAPS; i++) set_coef(i, (i == a) ? d : 0);
    endtask

    // Strobe one sample, optionally with a concurrent or mid-busy kernel write,
    // then wait (bounded) for emg_valid and check its latency and width.
    task automatic run_sample(input logic [NCH*CNT_W-1:0] vec, input bit cw_now,
                              input bit cw_busy, input int a, input int d, input string tag);
        int n;
        bit seen;
        @(negedge clk);
        spk_cnt    = vec;
        sample_stb = 1'b1;
        if (cw_now) begin
            coef_we = 1'b1; coef_addr = 4'(a); coef_data = 16'(d);
        end
        @(negedge clk);
        sample_stb = 1'b0;
        coef_we    = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
            if (cw_busy && n == 5) begin
                coef_we = 1'b1; coef_addr = 4'(a); coef_data = 16'(d);
            end
            if (cw_busy && n == 6) coef_we = 1'b0;
            if (emg_valid) seen = 1'b1;
        end
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
        @(posedge clk);
        #1;
        chk({tag, "_valid_1cyc"}, 64'(emg_valid), 64'd0);
    endtask

    initial begin
        int pulses;

        // Reset state
        do_reset();
        @(posedge clk); #1;
        chk("rst_out",     64'(emg_out), 64'd0);
        chk("rst_sum",     64'(emg_sum), 64'd0);
        chk("rst_valid",   64'(emg_valid), 64'd0);
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_coeferr", 64'(coef_err), 64'd0);

        // Identity kernel, counts {3,5,0,511}
        load_unit(0, 1);
        run_sample(mk(3, 5, 0, 511), 1'b0, 1'b0, 0, 0, "t1");
        chk("t1_ch0", ch32(0), 64'sd3);
        chk("t1_ch1", ch32(1), 64'sd5);
        chk("t1_ch2", ch32(2), 64'sd0);
        chk("t1_ch3", ch32(3), 64'sd511);
        chk("t1_sum", 64'(emg_sum), 64'sd519);
        chk("t1_s_ch3", ch20(3), 64'sd511);
        chk("t1_s_sum", 64'(emg_sum_s), 64'sd519);
        repeat (5) @(posedge clk);
        #1;
        chk("t1_hold", ch32(3), 64'sd511);

        // Ramp kernel coef[k]=k+1 with fresh history: 1, 4, 10
        do_reset();
        for (int i = 0; i < TAPS; i++) set_coef(i, i + 1);
        run_sample(mk(1, 0, 0, 0), 1'b0, 1'b0, 0, 0, "t2a");
        chk("t2a_ch0", ch32(0), 64'sd1);
        run_sample(mk(2, 0, 0, 0), 1'b0, 1'b0, 0, 0, "t2b");
        chk("t2b_ch0", ch32(0), 64'sd4);
        run_sample(mk(3, 0, 0, 0), 1'b0, 1'b0, 0, 0, "t2c");
        chk("t2c_ch0", ch32(0), 64'sd10);
        chk("t2c_ch1", ch32(1), 64'sd0);
        chk("t2c_sum", 64'(emg_sum), 64'sd10);

        // Most-negative coefficient: 511 * -32768
        do_reset();
        load_unit(0, -32768);
        run_sample(mk(511, 0, 0, 0), 1'b0, 1'b0, 0, 0, "t3");
        chk("t3_ch0",   ch32(0), -64'sd16744448);
        chk("t3_sum",   64'(emg_sum), -64'sd16744448);
        chk("t3_s_ch0", ch20(0), -64'sd524288);
        chk("t3_s_sum", 64'(emg_sum_s), -64'sd524288);

        // Overrun: second strobe 10 cycles after the first is dropped
        do_reset();
        @(negedge clk);
        spk_cnt = mk(1, 0, 0, 0);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (9) @(negedge clk);
        spk_cnt = mk(100, 0, 0, 0);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        pulses = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (emg_valid) pulses++;
        end
        chk("t4_pulses",  64'(pulses), 64'd1);
        chk("t4_overrun", 64'(overrun), 64'd1);
        chk("t4_ch0",     ch32(0), -64'sd32768);

        // Kernel write while busy is rejected; concurrent IDLE write is deferred
        do_reset();
        set_coef(0, 2);
        run_sample(mk(10, 0, 0, 0), 1'b0, 1'b1, 0, 7, "t5a");
        chk("t5a_ch0",     ch32(0), 64'sd20);
        chk("t5a_coeferr", 64'(coef_err), 64'd1);
        run_sample(mk(1, 0, 0, 0), 1'b1, 1'b0, 0, 5, "t5b");
        chk("t5b_ch0", ch32(0), 64'sd2);
        run_sample(mk(1, 0, 0, 0), 1'b0, 1'b0, 0, 0, "t5c");
        chk("t5c_ch0", ch32(0), 64'sd5);

        // Reset mid-ACCUM abandons the sample and clears history
        set_coef(1, 1);
        @(negedge clk);
        spk_cnt = mk(9, 0, 0, 0);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (emg_valid) pulses++;
        end
        chk("t6_pulses",  64'(pulses), 64'd0);
        chk("t6_out",     64'(emg_out), 64'd0);
        chk("t6_sum",     64'(emg_sum), 64'd0);
        chk("t6_busy",    64'(busy), 64'd0);
        chk("t6_overrun", 64'(overrun), 64'd0);
        chk("t6_coeferr", 64'(coef_err), 64'd0);
        run_sample(mk(3, 0, 0, 0), 1'b0, 1'b0, 0, 0, "t6b");
        chk("t6b_ch0", ch32(0), 64'sd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
